mem_wb_stage: RTL and testbench

Parametrised memory-access stage and M/W pipeline register for the 5-stage RISC-V core. It sits between the EX/M register and write-back. It drives a request/ready data-memory port with variable wait states and performs byte, halfword, word and (for XLEN=64) doubleword loads and stores with byte enables and sign/zero extension. It stalls the pipeline while an access is outstanding and flags misaligned or illegal accesses to write-back.

---
 rtl/mem_wb_stage_if.sv | 25 ++
 rtl/mem_wb_stage.sv | 157 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Request/ready data-memory port driven by the M stage of the pipeline.
// The stage is the master; the memory answers with dmem_ready and dmem_rdata.
interface mem_wb_stage_if #(
   parameter int XLEN = 32
);
   localparam int NB = XLEN / 8;

   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [NB-1:0]   dmem_be;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_ready;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage and M/W pipeline register: sized loads/stores over a
// request/ready port, pipeline stall during wait states, fault flagging.
module mem_wb_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            validM,
   input  logic            regwriteM,
   input  logic            memreadM,
   input  logic            memwriteM,
   input  logic [2:0]      funct3M,
   input  logic [1:0]      wbselM,
   input  logic [RA_W-1:0] rdM,
   input  logic [XLEN-1:0] data_writeM,
   input  logic [XLEN-1:0] ALUresM,
   input  logic [XLEN-1:0] pc4M,
   mem_wb_stage_if.master  dmem,
   output logic            stallM,
   output logic            validW,
   output logic            regwriteW,
   output logic [1:0]      wbselW,
   output logic [RA_W-1:0] rdW,
   output logic [XLEN-1:0] ALUresW,
   output logic [XLEN-1:0] data_readW,
   output logic [XLEN-1:0] pc4W,
   output logic            excW,
   output logic [XLEN-1:0] excaddrW
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t           state_r;
   logic             memop_s;
   logic             illegal_s;
   logic             misaligned_s;
   logic             exc_s;
   logic             legal_s;
   logic             req_s;
   logic [OFF_W-1:0] off_s;
   logic [OFF_W-1:0] align_mask_s;

   function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
      logic [NB-1:0] m;
      int            sb;
      sb = 32'sd1 << size;
      for (int i = 0; i < NB; i++) begin
         m[i] = (i >= int'(off)) && (i < int'(off) + sb);
      end
      return m;
   endfunction

   function automatic logic [XLEN-1:0] replicate(input logic [1:0] size, input logic [XLEN-1:0] d);
      logic [XLEN-1:0] r;
      int              sb;
      sb = 32'sd1 << size;
      for (int i = 0; i < NB; i++) begin
         r[i*8 +: 8] = d[(i % sb)*8 +: 8];
      end
      return r;
   endfunction

   // Narrow loads wider than the datapath (illegal) are clamped so indexing stays in range.
   function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [OFF_W-1:0] off,
                                                   input logic [XLEN-1:0] raw);
      logic [XLEN-1:0] sh;
      logic [XLEN-1:0] r;
      logic            fill;
      int              nbits;
      sh    = raw >> {off, 3'b000};
      nbits = ((32'sd8 << f3[1:0]) > XLEN) ? XLEN : (32'sd8 << f3[1:0]);
      fill  = f3[2] ? 1'b0 : sh[nbits-1];
      for (int i = 0; i < XLEN; i++) begin
         r[i] = (i < nbits) ? sh[i] : fill;
      end
      return r;
   endfunction

   assign off_s        = ALUresM[OFF_W-1:0];
   assign memop_s      = validM & (memreadM | memwriteM);
   assign align_mask_s = OFF_W'((32'd1 << funct3M[1:0]) - 32'd1);
   assign misaligned_s = |(off_s & align_mask_s);
   assign exc_s        = memop_s & (illegal_s | misaligned_s);
   assign legal_s      = memop_s & ~exc_s;

   // Decode funct3 encodings that have no meaning for this datapath width.
   always_comb begin
      illegal_s = 1'b0;
      if (XLEN == 32) begin
         case (funct3M)
            3'b011, 3'b110, 3'b111: illegal_s = 1'b1;
            3'b100, 3'b101:         illegal_s = memwriteM;
            default:                illegal_s = 1'b0;
         endcase
      end else begin
         case (funct3M)
            3'b111:                 illegal_s = 1'b1;
            3'b100, 3'b101, 3'b110: illegal_s = memwriteM;
            default:                illegal_s = 1'b0;
         endcase
      end
   end

   // Request is held through WAIT from the stable M inputs; stall never looks at read data.
   assign req_s           = legal_s | (state_r == WAIT);
   assign stallM          = req_s & ~dmem.dmem_ready;
   assign dmem.dmem_req   = req_s;
   assign dmem.dmem_we    = req_s & memwriteM;
   assign dmem.dmem_addr  = {ALUresM[XLEN-1:OFF_W], {OFF_W{1'b0}}};
   assign dmem.dmem_be    = req_s ? lane_mask(funct3M[1:0], off_s) : {NB{1'b0}};
   assign dmem.dmem_wdata = replicate(funct3M[1:0], data_writeM);

   // Access state: leave IDLE only when a legal request meets a wait state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         case (state_r)
            IDLE:    state_r <= (legal_s && !dmem.dmem_ready) ? WAIT : IDLE;
            WAIT:    state_r <= dmem.dmem_ready ? IDLE : WAIT;
            default: state_r <= IDLE;
         endcase
      end
   end

   // M/W register: bubble on stalled edges, otherwise capture the M-stage result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         validW     <= 1'b0;
         regwriteW  <= 1'b0;
         excW       <= 1'b0;
         wbselW     <= 2'b00;
         rdW        <= {RA_W{1'b0}};
         ALUresW    <= {XLEN{1'b0}};
         data_readW <= {XLEN{1'b0}};
         pc4W       <= {XLEN{1'b0}};
         excaddrW   <= {XLEN{1'b0}};
      end else if (stallM) begin
         validW    <= 1'b0;
         regwriteW <= 1'b0;
         excW      <= 1'b0;
      end else begin
         validW     <= validM;
         regwriteW  <= regwriteM & validM & ~exc_s;
         excW       <= exc_s;
         wbselW     <= wbselM;
         rdW        <= rdM;
         ALUresW    <= ALUresM;
         data_readW <= load_extend(funct3M, off_s, dmem.dmem_rdata);
         pc4W       <= pc4M;
         excaddrW   <= ALUresM;
      end
   end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed and random accesses on XLEN=32 and XLEN=64
// instances, checked against an arithmetic model of the access rules.
module tb_mem_wb_stage;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        v, rw, mr, mw, ready, sel64;
   logic [2:0]  f3;
   logic [1:0]  wbsel;
   logic [4:0]  rd;
   logic [63:0] wd, addr, pc4, rdata;

   int n_tests = 0;
   int n_fail  = 0;

   mem_wb_stage_if #(.XLEN(32)) bus32 ();
   mem_wb_stage_if #(.XLEN(64)) bus64 ();
   assign bus32.dmem_ready = ready;
   assign bus32.dmem_rdata = rdata[31:0];
   assign bus64.dmem_ready = ready;
   assign bus64.dmem_rdata = rdata;

   logic        stall32, valid32, regw32, exc32;
   logic [1:0]  wbsel32;
   logic [4:0]  rd32;
   logic [31:0] alu32, dr32, pc32, ea32;
   logic        stall64, valid64, regw64, exc64;
   logic [1:0]  wbsel64;
   logic [4:0]  rd64;
   logic [63:0] alu64, dr64, pc64, ea64;

   mem_wb_stage #(.XLEN(32), .RA_W(5)) dut32 (
      .clk(clk), .rst_n(rst_n), .validM(v), .regwriteM(rw), .memreadM(mr), .memwriteM(mw),
      .funct3M(f3), .wbselM(wbsel), .rdM(rd), .data_writeM(wd[31:0]), .ALUresM(addr[31:0]),
      .pc4M(pc4[31:0]), .dmem(bus32), .stallM(stall32), .validW(valid32), .regwriteW(regw32),
      .wbselW(wbsel32), .rdW(rd32), .ALUresW(alu32), .data_readW(dr32), .pc4W(pc32),
      .excW(exc32), .excaddrW(ea32)
   );

   mem_wb_stage #(.XLEN(64), .RA_W(5)) dut64 (
      .clk(clk), .rst_n(rst_n), .validM(v), .regwriteM(rw), .memreadM(mr), .memwriteM(mw),
      .funct3M(f3), .wbselM(wbsel), .rdM(rd), .data_writeM(wd), .ALUresM(addr),
      .pc4M(pc4), .dmem(bus64), .stallM(stall64), .validW(valid64), .regwriteW(regw64),
      .wbselW(wbsel64), .rdW(rd64), .ALUresW(alu64), .data_readW(dr64), .pc4W(pc64),
      .excW(exc64), .excaddrW(ea64)
   );

   // Observation view of whichever instance the current step targets.
   logic        req_o, we_o, stall_o, validW_o, regW_o, excW_o;
   logic [7:0]  be_o;
   logic [1:0]  wbselW_o;
   logic [4:0]  rdW_o;
   logic [63:0] addr_o, wdata_o, alu_o, dr_o, pc4_o, ea_o;
   assign req_o    = sel64 ? bus64.dmem_req : bus32.dmem_req;
   assign we_o     = sel64 ? bus64.dmem_we  : bus32.dmem_we;
   assign be_o     = sel64 ? bus64.dmem_be  : {4'h0, bus32.dmem_be};
   assign addr_o   = sel64 ? bus64.dmem_addr  : {32'h0, bus32.dmem_addr};
   assign wdata_o  = sel64 ? bus64.dmem_wdata : {32'h0, bus32.dmem_wdata};
   assign stall_o  = sel64 ? stall64 : stall32;
   assign validW_o = sel64 ? valid64 : valid32;
   assign regW_o   = sel64 ? regw64  : regw32;
   assign excW_o   = sel64 ? exc64   : exc32;
   assign wbselW_o = sel64 ? wbsel64 : wbsel32;
   assign rdW_o    = sel64 ? rd64    : rd32;
   assign alu_o    = sel64 ? alu64   : {32'h0, alu32};
   assign dr_o     = sel64 ? dr64    : {32'h0, dr32};
   assign pc4_o    = sel64 ? pc64    : {32'h0, pc32};
   assign ea_o     = sel64 ? ea64    : {32'h0, ea32};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: access rules expressed as masks, multiplication and shifts.
   task automatic model(input bit is64, input logic [2:0] fn, input logic m_w,
                        input logic [63:0] a, input logic [63:0] d, input logic [63:0] raw,
                        output bit exc, output logic [63:0] e_addr, output logic [7:0] e_be,
                        output logic [63:0] e_wdata, output logic [63:0] e_load);
      int          nb, sb, off;
      logic [63:0] msk, val, rep, xm;
      nb  = is64 ? 8 : 4;
      sb  = 1 << fn[1:0];
      off = int'(a[2:0]) % nb;
      xm  = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      if (is64) exc = (fn == 3'd7) || (m_w && fn[2]);
      else      exc = (fn == 3'd3) || (fn >= 3'd6) || (m_w && fn[2]);
      exc    = exc || ((off % sb) != 0);
      msk    = (sb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*sb)) - 64'd1);
      e_addr = a & xm & ~64'(nb - 1);
      e_be   = 8'(((1 << sb) - 1) << off);
      case (sb)
         1:       rep = 64'h0101_0101_0101_0101;
         2:       rep = 64'h0001_0001_0001_0001;
         4:       rep = 64'h0000_0001_0000_0001;
         default: rep = 64'h1;
      endcase
      e_wdata = ((d & msk) * rep) & xm;
      val = ((raw & xm) >> (8*off)) & msk;
      if (!fn[2] && val[8*sb-1]) val = val | ~msk;
      e_load = val & xm;
   endtask

   task automatic run_op(input bit is64, input logic iv, input logic irw, input logic imr,
                         input logic imw, input logic [2:0] fn, input logic [63:0] a,
                         input logic [63:0] d, input logic [63:0] raw, input int waits);
      bit          exc, legal;
      logic [63:0] e_addr, e_wdata, e_load, xm;
      logic [7:0]  e_be;
      model(is64, fn, imw, a, d, raw, exc, e_addr, e_be, e_wdata, e_load);
      exc   = exc && iv && (imr || imw);
      legal = iv && (imr || imw) && !exc;
      xm    = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      @(negedge clk);
      sel64 = is64; v = iv; rw = irw; mr = imr; mw = imw; f3 = fn;
      addr = a; wd = d; rdata = raw;
      wbsel = 2'($urandom); rd = 5'($urandom); pc4 = {$urandom, $urandom};
      ready = (waits == 0) || !legal;
      #1;
      check("req", req_o, legal);
      check("stall", stall_o, legal && (waits > 0));
      if (legal) begin
         check("addr", addr_o, e_addr);
         check("be", be_o, e_be);
         check("we", we_o, imw);
         if (imw) check("wdata", wdata_o, e_wdata);
      end
      for (int w = 0; legal && (w < waits); w++) begin
         @(posedge clk); #1;
         check("bubble_valid", validW_o, 1'b0);
         check("bubble_regw", regW_o, 1'b0);
         @(negedge clk);
         if (w == waits - 1) ready = 1'b1;
         #1;
         check("hold_req", req_o, 1'b1);
         check("hold_addr", addr_o, e_addr);
         check("wait_stall", stall_o, w != waits - 1);
      end
      @(posedge clk); #1;
      check("validW", validW_o, iv);
      check("regwriteW", regW_o, irw && iv && !exc);
      check("excW", excW_o, exc);
      check("rdW", rdW_o, rd);
      check("wbselW", wbselW_o, wbsel);
      check("pc4W", pc4_o, pc4 & xm);
      check("ALUresW", alu_o, a & xm);
      if (exc) check("excaddrW", ea_o, a & xm);
      if (legal && imr && !imw) check("data_readW", dr_o, e_load);
   endtask

   initial begin
      rst_n = 1'b0; sel64 = 1'b0; ready = 1'b1;
      v = 1'b0; rw = 1'b0; mr = 1'b0; mw = 1'b0; f3 = 3'd0; wbsel = 2'd0; rd = 5'd0;
      wd = 64'd0; addr = 64'd0; pc4 = 64'd0; rdata = 64'd0;
      #2;
      check("rst_validW", validW_o, 1'b0);
      check("rst_regW", regW_o, 1'b0);
      check("rst_excW", excW_o, 1'b0);
      check("rst_data", dr_o | alu_o | pc4_o | ea_o, 64'd0);
      check("rst_req", req_o, 1'b0);
      @(negedge clk); rst_n = 1'b1;

      run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 64'h100, 64'hDEADBEEF, 64'd0, 0);
      check("sw_be", be_o, 8'h0F);
      check("sw_wdata", wdata_o, 64'hDEADBEEF);
      run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 64'h103, 64'h12345680, 64'd0, 0);
      check("sb_addr", addr_o, 64'h100);
      check("sb_be", be_o, 8'h08);
      check("sb_wdata", wdata_o, 64'h80808080);
      run_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 64'h102, 64'd0, 64'h00800000, 0);
      check("lb_data", dr_o, 64'hFFFFFF80);
      run_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 64'h102, 64'd0, 64'h00800000, 0);
      check("lbu_data", dr_o, 64'h00000080);
      run_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 64'h104, 64'd0, 64'hCAFEF00D, 3);
      check("lw_wait_data", dr_o, 64'hCAFEF00D);
      run_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 64'h101, 64'd0, 64'd0, 0);
      check("lh_mis_exc", excW_o, 1'b1);
      check("lh_mis_addr", ea_o, 64'h101);
      run_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 64'h100, 64'd0, 64'd0, 0);
      check("f3_011_exc", excW_o, 1'b1);
      run_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 64'h55, 64'd0, 64'd0, 0);
      run_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 64'h8, 64'd0, 64'h8000_0000_1234_5678, 2);
      check("ld_be", be_o, 8'hFF);
      run_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b110, 64'h14, 64'd0, 64'h9000_0000_0000_0000, 0);
      check("lwu_data", dr_o, 64'h0000_0000_9000_0000);

      // Abort an outstanding access with reset.
      @(negedge clk);
      sel64 = 1'b0; v = 1'b1; rw = 1'b1; mr = 1'b1; mw = 1'b0; f3 = 3'b010; addr = 64'h200; ready = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_stall", stall_o, 1'b1);
      @(negedge clk); rst_n = 1'b0; #1;
      check("mid_rst_validW", validW_o, 1'b0);
      check("mid_rst_regW", regW_o, 1'b0);
      check("mid_rst_data", dr_o | alu_o | pc4_o | ea_o | 64'(rdW_o) | 64'(wbselW_o), 64'd0);
      v = 1'b0;
      @(negedge clk); rst_n = 1'b1; #1;
      check("post_rst_req", req_o, 1'b0);
      check("post_rst_stall", stall_o, 1'b0);

      for (int n = 0; n < 150; n++) begin
         bit          r64;
         logic [2:0]  fn, lo;
         logic [63:0] a;
         int          kind;
         r64  = 1'($urandom);
         fn   = 3'($urandom);
         kind = $urandom_range(0, 3);
         a    = {$urandom, $urandom};
         lo   = 3'($urandom);
         if ($urandom_range(0, 3) != 0) lo = lo & ~3'((1 << fn[1:0]) - 1);
         a[2:0] = lo;
         run_op(r64, $urandom_range(0, 7) != 0, 1'($urandom), kind == 1 || kind == 3, kind == 2,
                fn, a, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
